// File: rtl/reg_access_ctrl.sv
// Register file initiator: sequences READ/WRITE/MOVE/SWAP commands into single-cycle
// register file bus operations and returns one response per command.
module reg_access_ctrl #(
    parameter int OPERAND_SIZE = 8,
    parameter int NUM_REGS     = 8,
    parameter int SEL_W        = 8
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    cmd_valid,
    output logic                    cmd_ready,
    input  logic [1:0]              cmd_op,
    input  logic [SEL_W-1:0]        cmd_rs,
    input  logic [SEL_W-1:0]        cmd_rd,
    input  logic [OPERAND_SIZE-1:0] cmd_data,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [OPERAND_SIZE-1:0] rsp_data,
    output logic                    rsp_err,
    output logic                    busy,
    output logic                    rf_enable,
    output logic                    rf_read,
    output logic                    rf_write,
    output logic [SEL_W-1:0]        rf_select,
    output logic [OPERAND_SIZE-1:0] rf_data_in,
    input  logic [OPERAND_SIZE-1:0] rf_data_out
);

    typedef enum logic [2:0] {IDLE, RD1, RD2, WR1, WR2, RESP} state_t;

    localparam logic [1:0] OP_READ  = 2'b00;
    localparam logic [1:0] OP_WRITE = 2'b01;
    localparam logic [1:0] OP_MOVE  = 2'b10;
    localparam logic [1:0] OP_SWAP  = 2'b11;

    state_t                  state_q;
    logic [1:0]              op_q;
    logic [SEL_W-1:0]        rs_q;
    logic [SEL_W-1:0]        rd_q;
    logic [OPERAND_SIZE-1:0] wdata_q;
    logic [OPERAND_SIZE-1:0] tmpA_q;
    logic [OPERAND_SIZE-1:0] tmpB_q;
    logic                    secondRead_q;
    logic                    err_q;

    logic                    cmd_ready_q;
    logic                    rsp_valid_q;
    logic [OPERAND_SIZE-1:0] rsp_data_q;
    logic                    rsp_err_q;
    logic                    busy_q;
    logic                    rf_enable_q;
    logic                    rf_read_q;
    logic                    rf_write_q;
    logic [SEL_W-1:0]        rf_select_q;
    logic [OPERAND_SIZE-1:0] rf_data_in_q;

    logic [OPERAND_SIZE-1:0] tmpA_d;
    logic [OPERAND_SIZE-1:0] tmpB_d;
    logic                    cmdErr;

    function automatic logic outOfRange(input logic [SEL_W-1:0] idx);
        return 32'(idx) >= 32'(NUM_REGS);
    endfunction

    // A read issued last cycle lands here; the first read of a command fills tmpA, the second tmpB.
    always_comb begin
        tmpA_d = tmpA_q;
        tmpB_d = tmpB_q;
        if (rf_read_q && !secondRead_q) tmpA_d = rf_data_out;
        if (rf_read_q && secondRead_q)  tmpB_d = rf_data_out;
    end

    always_comb begin
        cmdErr = 1'b0;
        case (cmd_op)
            OP_READ:  cmdErr = outOfRange(cmd_rs);
            OP_WRITE: cmdErr = outOfRange(cmd_rd);
            default:  cmdErr = outOfRange(cmd_rs) || outOfRange(cmd_rd);
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            op_q         <= '0;
            rs_q         <= '0;
            rd_q         <= '0;
            wdata_q      <= '0;
            tmpA_q       <= '0;
            tmpB_q       <= '0;
            secondRead_q <= 1'b0;
            err_q        <= 1'b0;
            cmd_ready_q  <= 1'b0;
            rsp_valid_q  <= 1'b0;
            rsp_data_q   <= '0;
            rsp_err_q    <= 1'b0;
            busy_q       <= 1'b0;
            rf_enable_q  <= 1'b0;
            rf_read_q    <= 1'b0;
            rf_write_q   <= 1'b0;
            rf_select_q  <= '0;
            rf_data_in_q <= '0;
        end else begin
            tmpA_q       <= tmpA_d;
            tmpB_q       <= tmpB_d;
            if (rf_read_q) secondRead_q <= 1'b1;
            rf_enable_q  <= 1'b0;
            rf_read_q    <= 1'b0;
            rf_write_q   <= 1'b0;
            rf_select_q  <= '0;
            rf_data_in_q <= '0;

            case (state_q)
                IDLE: begin
                    if (cmd_ready_q && cmd_valid) begin
                        op_q         <= cmd_op;
                        rs_q         <= cmd_rs;
                        rd_q         <= cmd_rd;
                        wdata_q      <= cmd_data;
                        err_q        <= cmdErr;
                        secondRead_q <= 1'b0;
                        cmd_ready_q  <= 1'b0;
                        busy_q       <= 1'b1;
                        if (cmdErr)                 state_q <= RESP;
                        else if (cmd_op == OP_WRITE) state_q <= WR1;
                        else                        state_q <= RD1;
                    end else begin
                        cmd_ready_q <= !rsp_valid_q;
                    end
                end
                RD1: begin
                    rf_enable_q <= 1'b1;
                    rf_read_q   <= 1'b1;
                    rf_select_q <= rs_q;
                    if (op_q == OP_READ)      state_q <= RESP;
                    else if (op_q == OP_MOVE) state_q <= WR1;
                    else                      state_q <= RD2;
                end
                RD2: begin
                    rf_enable_q <= 1'b1;
                    rf_read_q   <= 1'b1;
                    rf_select_q <= rd_q;
                    state_q     <= WR1;
                end
                WR1: begin
                    rf_enable_q  <= 1'b1;
                    rf_write_q   <= 1'b1;
                    rf_select_q  <= rd_q;
                    rf_data_in_q <= (op_q == OP_WRITE) ? wdata_q : tmpA_d;
                    state_q      <= (op_q == OP_SWAP) ? WR2 : RESP;
                end
                WR2: begin
                    rf_enable_q  <= 1'b1;
                    rf_write_q   <= 1'b1;
                    rf_select_q  <= rs_q;
                    rf_data_in_q <= tmpB_d;
                    state_q      <= RESP;
                end
                RESP: begin
                    if (!rsp_valid_q) begin
                        rsp_valid_q <= 1'b1;
                        rsp_err_q   <= err_q;
                        if (err_q)                 rsp_data_q <= '0;
                        else if (op_q == OP_WRITE) rsp_data_q <= wdata_q;
                        else                       rsp_data_q <= tmpA_d;
                    end else if (rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        rsp_err_q   <= 1'b0;
                        rsp_data_q  <= '0;
                        busy_q      <= 1'b0;
                        state_q     <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign cmd_ready  = cmd_ready_q;
    assign rsp_valid  = rsp_valid_q;
    assign rsp_data   = rsp_data_q;
    assign rsp_err    = rsp_err_q;
    assign busy       = busy_q;
    assign rf_enable  = rf_enable_q;
    assign rf_read    = rf_read_q;
    assign rf_write   = rf_write_q;
    assign rf_select  = rf_select_q;
    assign rf_data_in = rf_data_in_q;

endmodule

// File: tb/tb_reg_access_ctrl.sv
// Scoreboard bench for reg_access_ctrl: a behavioural register file answers the bus,
// a reference model predicts bus ops and responses, monitors compare on the falling edge.
module tb_reg_access_ctrl;

    localparam int OPERAND_SIZE = 8;
    localparam int NUM_REGS     = 8;
    localparam int SEL_W        = 8;

    localparam logic [1:0] OP_READ  = 2'b00;
    localparam logic [1:0] OP_WRITE = 2'b01;
    localparam logic [1:0] OP_MOVE  = 2'b10;
    localparam logic [1:0] OP_SWAP  = 2'b11;

    logic                    clk = 1'b0;
    logic                    reset = 1'b1;
    logic                    cmd_valid = 1'b0;
    logic                    cmd_ready;
    logic [1:0]              cmd_op = '0;
    logic [SEL_W-1:0]        cmd_rs = '0;
    logic [SEL_W-1:0]        cmd_rd = '0;
    logic [OPERAND_SIZE-1:0] cmd_data = '0;
    logic                    rsp_valid;
    logic                    rsp_ready = 1'b1;
    logic [OPERAND_SIZE-1:0] rsp_data;
    logic                    rsp_err;
    logic                    busy;
    logic                    rf_enable;
    logic                    rf_read;
    logic                    rf_write;
    logic [SEL_W-1:0]        rf_select;
    logic [OPERAND_SIZE-1:0] rf_data_in;
    logic [OPERAND_SIZE-1:0] rf_data_out = '0;

    reg_access_ctrl #(
        .OPERAND_SIZE(OPERAND_SIZE),
        .NUM_REGS    (NUM_REGS),
        .SEL_W       (SEL_W)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_op     (cmd_op),
        .cmd_rs     (cmd_rs),
        .cmd_rd     (cmd_rd),
        .cmd_data   (cmd_data),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_data   (rsp_data),
        .rsp_err    (rsp_err),
        .busy       (busy),
        .rf_enable  (rf_enable),
        .rf_read    (rf_read),
        .rf_write   (rf_write),
        .rf_select  (rf_select),
        .rf_data_in (rf_data_in),
        .rf_data_out(rf_data_out)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [OPERAND_SIZE-1:0] data;
        logic                    err;
        int unsigned             cyc;
    } rsp_t;

    typedef struct {
        logic                    wr;
        logic [SEL_W-1:0]        sel;
        logic [OPERAND_SIZE-1:0] data;
    } bus_t;

    rsp_t                    rspQ[$];
    bus_t                    busQ[$];
    rsp_t                    rspExp;
    bus_t                    busExp;
    logic [OPERAND_SIZE-1:0] model [NUM_REGS];
    logic [OPERAND_SIZE-1:0] rfMem [NUM_REGS];
    int unsigned             cycle = 0;
    int                      compared = 0;
    int                      mismatched = 0;
    bit                      rspSeen = 1'b0;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        compared++;
        if (observed !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    always @(posedge clk) cycle <= cycle + 1;

    // Register file model: samples strobes on the falling edge, read data valid afterwards.
    always @(negedge clk) begin
        if (rf_enable && 32'(rf_select) < 32'(NUM_REGS)) begin
            if (rf_write) rfMem[rf_select] <= rf_data_in;
            if (rf_read)  rf_data_out      <= rfMem[rf_select];
        end
    end

    always @(negedge clk) begin
        if (rf_enable) begin
            if (busQ.size() == 0) begin
                checkOutput("busUnexpected", 32'(rf_select) + 32'h100, 32'h0);
            end else begin
                busExp = busQ.pop_front();
                checkOutput("busRdWr", 32'({rf_read, rf_write}), busExp.wr ? 32'h1 : 32'h2);
                checkOutput("busSelect", 32'(rf_select), 32'(busExp.sel));
                if (busExp.wr) checkOutput("busDataIn", 32'(rf_data_in), 32'(busExp.data));
            end
        end else if (rf_read || rf_write) begin
            checkOutput("strobeNoEnable", 32'({rf_read, rf_write}), 32'h0);
        end
    end

    always @(negedge clk) begin
        if (!rsp_valid) begin
            rspSeen = 1'b0;
        end else if (!rspSeen) begin
            rspSeen = 1'b1;
            if (rspQ.size() == 0) begin
                checkOutput("rspUnexpected", 32'h1, 32'h0);
            end else begin
                rspExp = rspQ.pop_front();
                checkOutput("rspErr", 32'(rsp_err), 32'(rspExp.err));
                if (!rspExp.err) checkOutput("rspData", 32'(rsp_data), 32'(rspExp.data));
                checkOutput("rspLatency", cycle, rspExp.cyc);
            end
        end
    end

    function automatic bit idxBad(input logic [SEL_W-1:0] idx);
        return 32'(idx) >= 32'(NUM_REGS);
    endfunction

    task automatic pushBus(input logic wr, input logic [SEL_W-1:0] sel, input logic [OPERAND_SIZE-1:0] data);
        bus_t b;
        b.wr = wr;
        b.sel = sel;
        b.data = data;
        busQ.push_back(b);
    endtask

    // Predict bus ops and the response for a command accepted at edge acceptCycle.
    task automatic queueExpectations(input logic [1:0] op, input logic [SEL_W-1:0] rs,
                                     input logic [SEL_W-1:0] rd, input logic [OPERAND_SIZE-1:0] data,
                                     input int unsigned acceptCycle);
        rsp_t r;
        logic [OPERAND_SIZE-1:0] a;
        logic [OPERAND_SIZE-1:0] b;
        case (op)
            OP_READ:  r.err = idxBad(rs);
            OP_WRITE: r.err = idxBad(rd);
            default:  r.err = idxBad(rs) || idxBad(rd);
        endcase
        r.data = '0;
        if (r.err) begin
            r.cyc = acceptCycle + 1;
        end else begin
            case (op)
                OP_READ: begin
                    pushBus(1'b0, rs, '0);
                    r.data = model[rs];
                    r.cyc = acceptCycle + 2;
                end
                OP_WRITE: begin
                    pushBus(1'b1, rd, data);
                    model[rd] = data;
                    r.data = data;
                    r.cyc = acceptCycle + 2;
                end
                OP_MOVE: begin
                    a = model[rs];
                    pushBus(1'b0, rs, '0);
                    pushBus(1'b1, rd, a);
                    model[rd] = a;
                    r.data = a;
                    r.cyc = acceptCycle + 3;
                end
                default: begin
                    a = model[rs];
                    b = model[rd];
                    pushBus(1'b0, rs, '0);
                    pushBus(1'b0, rd, '0);
                    pushBus(1'b1, rd, a);
                    pushBus(1'b1, rs, b);
                    model[rd] = a;
                    model[rs] = b;
                    r.data = a;
                    r.cyc = acceptCycle + 5;
                end
            endcase
        end
        rspQ.push_back(r);
    endtask

    task automatic applyStimulus(input logic [1:0] op, input logic [SEL_W-1:0] rs,
                                 input logic [SEL_W-1:0] rd, input logic [OPERAND_SIZE-1:0] data);
        int waitCnt = 0;
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_op = op;
        cmd_rs = rs;
        cmd_rd = rd;
        cmd_data = data;
        while (!cmd_ready && waitCnt < 40) begin
            @(negedge clk);
            waitCnt++;
        end
        if (!cmd_ready) begin
            checkOutput("cmdAcceptTimeout", 32'h0, 32'h1);
            cmd_valid = 1'b0;
            return;
        end
        queueExpectations(op, rs, rd, data, cycle + 1);
        @(posedge clk);
        #1 cmd_valid = 1'b0;
    endtask

    task automatic waitIdle();
        int n = 0;
        while ((rspQ.size() != 0 || busQ.size() != 0 || busy) && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (rspQ.size() != 0 || busQ.size() != 0 || busy) begin
            checkOutput("idleTimeout", 32'(rspQ.size() + busQ.size()), 32'h0);
            rspQ.delete();
            busQ.delete();
        end
    endtask

    task automatic backpressureTest();
        int n = 0;
        waitIdle();
        rsp_ready = 1'b0;
        applyStimulus(OP_READ, 8'd3, 8'd0, 8'h00);
        while (!rsp_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            checkOutput("holdRspValid", 32'(rsp_valid), 32'h1);
            checkOutput("holdRspData", 32'(rsp_data), 32'(model[3]));
            checkOutput("holdCmdReady", 32'(cmd_ready), 32'h0);
            checkOutput("holdRfEnable", 32'(rf_enable), 32'h0);
        end
        rsp_ready = 1'b1;
        waitIdle();
    endtask

    // Reset lands while the second read of a SWAP is on the bus; the command must vanish.
    task automatic abortSwapTest();
        int waitCnt = 0;
        int unsigned acc;
        waitIdle();
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_op = OP_SWAP;
        cmd_rs = 8'd1;
        cmd_rd = 8'd2;
        while (!cmd_ready && waitCnt < 40) begin
            @(negedge clk);
            waitCnt++;
        end
        acc = cycle + 1;
        pushBus(1'b0, 8'd1, '0);
        pushBus(1'b0, 8'd2, '0);
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        waitCnt = 0;
        while (cycle != acc + 2 && waitCnt < 20) begin
            @(negedge clk);
            waitCnt++;
        end
        #2 reset = 1'b0;
        #1;
        checkOutput("abortRfEnable", 32'(rf_enable), 32'h0);
        checkOutput("abortRfRead", 32'(rf_read), 32'h0);
        checkOutput("abortBusy", 32'(busy), 32'h0);
        checkOutput("abortRspValid", 32'(rsp_valid), 32'h0);
        checkOutput("abortCmdReady", 32'(cmd_ready), 32'h0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1 checkOutput("cmdReadyAfterAbort", 32'(cmd_ready), 32'h1);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            checkOutput("noRspAfterAbort", 32'(rsp_valid), 32'h0);
        end
        checkOutput("abortBusDrained", 32'(busQ.size()), 32'h0);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        for (int i = 0; i < NUM_REGS; i++) begin
            model[i] = '0;
            rfMem[i] = '0;
        end
        #1 reset = 1'b0;
        #2;
        checkOutput("resetCmdReady", 32'(cmd_ready), 32'h0);
        checkOutput("resetRspValid", 32'(rsp_valid), 32'h0);
        checkOutput("resetBusy", 32'(busy), 32'h0);
        checkOutput("resetRfEnable", 32'(rf_enable), 32'h0);
        checkOutput("resetRspData", 32'(rsp_data), 32'h0);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1 checkOutput("cmdReadyAfterReset", 32'(cmd_ready), 32'h1);

        applyStimulus(OP_WRITE, 8'd0, 8'd3, 8'hA5);
        applyStimulus(OP_READ,  8'd3, 8'd0, 8'h00);
        applyStimulus(OP_WRITE, 8'd0, 8'd1, 8'h11);
        applyStimulus(OP_WRITE, 8'd0, 8'd2, 8'h22);
        applyStimulus(OP_SWAP,  8'd1, 8'd2, 8'h00);
        applyStimulus(OP_READ,  8'd1, 8'd0, 8'h00);
        applyStimulus(OP_READ,  8'd2, 8'd0, 8'h00);
        applyStimulus(OP_MOVE,  8'd9, 8'd0, 8'h00);
        applyStimulus(OP_MOVE,  8'd2, 8'd5, 8'h00);
        applyStimulus(OP_READ,  8'd5, 8'd0, 8'h00);
        applyStimulus(OP_WRITE, 8'd0, 8'd4, 8'h5A);
        applyStimulus(OP_SWAP,  8'd4, 8'd4, 8'h00);
        applyStimulus(OP_READ,  8'd4, 8'd0, 8'h00);
        applyStimulus(OP_MOVE,  8'd3, 8'd3, 8'h00);
        applyStimulus(OP_WRITE, 8'd0, 8'd8, 8'hFF);
        applyStimulus(OP_READ,  8'd255, 8'd0, 8'h00);

        backpressureTest();
        abortSwapTest();
        applyStimulus(OP_READ, 8'd1, 8'd0, 8'h00);
        applyStimulus(OP_READ, 8'd2, 8'd0, 8'h00);

        for (int i = 0; i < 20; i++) begin
            applyStimulus(2'($urandom_range(0, 3)), 8'($urandom_range(0, 9)),
                          8'($urandom_range(0, 9)), 8'($urandom_range(0, 255)));
        end
        for (int i = 0; i < NUM_REGS; i++) begin
            applyStimulus(OP_READ, 8'(i), 8'd0, 8'h00);
        end
        waitIdle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
